// File: rtl/shared_pkg.sv
// ---------------------------------------------------------------------------
// shared_pkg
// Purpose : Definitions shared by the FIFO reader top level and its skid
//           buffer. Holds the default data width, the buffer depth and the
//           reader state encoding.
// Contents: FIFO_WIDTH_DEF - default FIFO data word width
//           SKID_DEPTH     - number of entries in the output skid buffer
//           state_e        - reader FSM states (IDLE, RUN, STOP)
// ---------------------------------------------------------------------------
package shared_pkg;

   localparam int FIFO_WIDTH_DEF = 16;
   localparam int SKID_DEPTH     = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

endpackage : shared_pkg

// File: rtl/fifo_reader_skid.sv
// ---------------------------------------------------------------------------
// fifo_reader_skid
// Purpose : Two-entry in-order buffer between the FIFO read port and the
//           downstream valid/ready interface.
// Ports   : clk        - clock, rising edge
//           rst_n      - asynchronous active-low reset, empties the buffer
//           push       - write push_data into the tail this cycle
//           push_data  - word to write
//           pop        - remove the head entry this cycle
//           occupancy  - number of valid entries (0..2)
//           head_data  - oldest entry (zero after reset)
// A push into a full buffer is only accepted if the head leaves on the
// same edge; a pop of an empty buffer is ignored.
// ---------------------------------------------------------------------------
module fifo_reader_skid
   import shared_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       occupancy,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] mem_q [SKID_DEPTH];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic             push_ok;
   logic             pop_ok;

   assign pop_ok  = pop && (occ_q != 2'd0);
   assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

   generate
      for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_q[gi] <= '0;
            end else if (push_ok && (wr_ptr_q == 1'(gi))) begin
               mem_q[gi] <= push_data;
            end
         end
      end
   endgenerate

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push_ok;
      rd_ptr_d = rd_ptr_q ^ pop_ok;
      occ_d    = occ_q;
      case ({push_ok, pop_ok})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign occupancy = occ_q;
   assign head_data = mem_q[rd_ptr_q];

endmodule : fifo_reader_skid

// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
// Purpose : Drains a 1-cycle-latency FIFO into a valid/ready stream through
//           a 2-entry skid buffer, counting delivered words.
// Ports   : clk           - clock, rising edge
//           rst_n         - asynchronous active-low reset
//           drain_en      - enables popping the FIFO
//           rd_en         - FIFO read strobe
//           data_out      - FIFO read data (valid one cycle after rd_en)
//           empty         - FIFO empty flag
//           underflow     - FIFO underflow flag
//           m_valid       - downstream data valid
//           m_ready       - downstream accept
//           m_data        - downstream data (oldest buffered word)
//           busy          - FSM not in IDLE
//           rd_count      - words delivered, wraps at 2^CNT_WIDTH
//           err_underflow - sticky underflow error
// Build option: define FIFO_READER_UNDERFLOW_CHK_EN to enable the sticky
//           underflow check; otherwise err_underflow is tied to 0.
// ---------------------------------------------------------------------------
module fifo_reader
   import shared_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  drain_en,
   output logic                  rd_en,
   input  logic [FIFO_WIDTH-1:0] data_out,
   input  logic                  empty,
   input  logic                  underflow,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  err_underflow
);

   state_e               state_q, state_d;
   logic                 inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [1:0]           occ;
   logic                 xfer;
   logic [2:0]           level;
   logic                 has_room;

   assign xfer = m_valid && m_ready;

   // Words already committed (buffered + in flight) minus the one leaving
   // this edge; a new read is allowed only if it still fits in two slots.
   assign level    = {1'b0, occ} + {2'b00, inflight_q};
   assign has_room = (level - {2'b00, xfer}) < 3'd2;

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (drain_en) state_d = RUN;
         RUN:  if (!drain_en) state_d = STOP;
         STOP: begin
            if (drain_en) begin
               state_d = RUN;
            end else if (!inflight_q && (occ == 2'd0)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- output logic ----
   always_comb begin
      rd_en = 1'b0;
      busy  = (state_q != IDLE);
      if ((state_q == RUN) && !empty && has_room) begin
         rd_en = 1'b1;
      end
   end

   // rd_en already implies a non-empty FIFO, so every strobe returns a word.
   assign inflight_d = rd_en;
   assign count_d    = count_q + CNT_WIDTH'(xfer);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         count_q    <= '0;
      end else begin
         inflight_q <= inflight_d;
         count_q    <= count_d;
      end
   end

   fifo_reader_skid #(
      .WIDTH (FIFO_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (data_out),
      .pop       (xfer),
      .occupancy (occ),
      .head_data (m_data)
   );

   assign m_valid  = (occ != 2'd0);
   assign rd_count = count_q;

`ifdef FIFO_READER_UNDERFLOW_CHK_EN
   logic err_q, err_d;

   assign err_d = err_q || underflow || (rd_en && empty);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_underflow = err_q;
`else
   logic unused_underflow;

   assign unused_underflow = underflow;
   assign err_underflow    = 1'b0;
`endif

endmodule : fifo_reader

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, FIFO data word width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, delivered-word counter width.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on posedge; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: drain_en  in  1  enables popping; rd_en  out  1  FIFO read strobe; data_out  in  FIFO_WIDTH  FIFO read data; empty  in  1  FIFO empty; underflow  in  1  FIFO underflow flag.
REQ-005 SHALL have ports: m_valid  out  1  downstream data valid; m_ready  in  1  downstream accept; m_data  out  FIFO_WIDTH  downstream data; busy  out  1  state != IDLE; rd_count  out  CNT_WIDTH  words delivered; err_underflow  out  1  sticky underflow error.

Function
REQ-006 SHALL treat FIFO read latency as 1 cycle: rd_en=1 with empty=0 sampled at edge N makes data_out valid for capture at edge N+1.
REQ-007 SHALL hold popped words in a 2-entry skid buffer; m_valid=1 whenever buffer occupancy>0; m_data = oldest entry.
REQ-008 SHALL complete a transfer when m_valid&&m_ready at a posedge; the entry is removed on that edge.
REQ-009 SHALL assert rd_en only when state==RUN, empty==0, and occupancy + in-flight reads (0 or 1) < 2 after accounting for a same-cycle transfer.
REQ-010 SHALL never drop or duplicate a word; order out equals FIFO pop order.
REQ-011 SHALL implement FSM IDLE, RUN, STOP: IDLE->RUN when drain_en=1; RUN->STOP when drain_en=0; STOP->IDLE when no read in flight and occupancy==0; STOP->RUN if drain_en returns to 1.
REQ-012 SHALL deassert rd_en in IDLE and STOP; STOP still captures in-flight data and presents buffered words downstream.
REQ-013 SHALL increment rd_count by 1 per completed transfer, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-014 SHALL sustain 1 word/cycle throughput when empty=0 and m_ready=1 continuously, after 2-cycle fill latency (drain_en rise to first m_valid).
REQ-015 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-016 SHALL handle simultaneous capture and transfer in one cycle with occupancy unchanged.

Reset
REQ-017 SHALL on rst_n=0, asynchronously: state=IDLE, rd_en=0, m_valid=0, m_data=0, occupancy=0, in-flight=0, busy=0, rd_count=0, err_underflow=0.
REQ-018 SHALL discard buffered and in-flight words on reset mid-operation; after release the first delivered word is the next FIFO pop.

Configuration
REQ-019 SHALL with macro FIFO_READER_UNDERFLOW_CHK_EN defined set err_underflow=1 at the edge after underflow=1 is sampled, or after rd_en=1 coincides with empty=1, held until reset.
REQ-020 SHALL without FIFO_READER_UNDERFLOW_CHK_EN tie err_underflow to 0 and omit the check logic; port list unchanged.

Structure
REQ-021 SHALL place FIFO_WIDTH default and the state enum typedef (IDLE, RUN, STOP) in shared_pkg.
REQ-022 SHALL implement the 2-entry buffer as sub-module fifo_reader_skid (push, pop, occupancy, head data); FSM, rd_en and counters live in fifo_reader.

Verification
REQ-023 SHALL cover: FIFO preloaded 0x0001..0x0008, drain_en=1, m_ready=1 -> m_data 0x0001..0x0008 on consecutive cycles, rd_count=8, rd_en never high with empty=1.
REQ-024 SHALL cover: 4 words, m_ready=0 for 10 cycles then 1 -> exactly 2 rd_en pulses during stall, m_data holds 0x0001, then 4 words in order.
REQ-025 SHALL cover: drain_en dropped while 1 read in flight -> state STOP, in-flight word delivered, busy falls once occupancy=0, no further rd_en.
REQ-026 SHALL cover: rst_n pulsed low mid-stream with 2 words buffered -> m_valid=0, rd_count=0 immediately; after release next word delivered is next FIFO entry.
REQ-027 SHALL cover: CNT_WIDTH=4, 17 transfers -> rd_count=1 (wrap).
REQ-028 SHALL cover: macro defined, underflow forced 1 for 1 cycle -> err_underflow=1 next edge and sticky; macro undefined -> err_underflow stays 0.
